loop_seq_ctrl: RTL and testbench

LOOP_SEQ_CTRL -- requirements
Module: loop_seq_ctrl

---
 rtl/loop_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_loop_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/loop_seq_ctrl.sv
// Loop sequencing controller: runs one counted loop per accepted start, with
// per-iteration start/end pulses, early exit through abort and a two-cycle epilogue.
module loop_seq_ctrl #(
    parameter int FSM_WIDTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ap_start,
    input  logic [CNT_WIDTH-1:0] trip_count,
    input  logic                 body_done,
    input  logic                 abort,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic [FSM_WIDTH-1:0] cur_state,
    output logic [CNT_WIDTH-1:0] iter_idx,
    output logic                 iter_start,
    output logic                 iter_end,
    output logic                 loop_quit,
    output logic                 finish
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRE        = 3'd1,
        S_ITER_START = 3'd2,
        S_BODY       = 3'd3,
        S_ITER_END   = 3'd4,
        S_QUIT       = 3'd5,
        S_POST0      = 3'd6,
        S_POST1      = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] iter_idx_q, iter_idx_d;
    logic [CNT_WIDTH-1:0] trip_q, trip_d;
    logic                 finish_q, finish_d;
    logic                 last_iter;

    // Handshake: ap_start is a level request. It is taken (trip_count sampled)
    // on any edge where the controller sits in IDLE or POST1 with ap_start high;
    // POST1 is the ap_ready cycle, so a held ap_start chains invocations back-to-back.
    assign last_iter = (iter_idx_q == (trip_q - CNT_WIDTH'(1)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            iter_idx_q <= '0;
            trip_q     <= '0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_idx_q <= iter_idx_d;
            trip_q     <= trip_d;
            finish_q   <= finish_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_idx_d = iter_idx_q;
        trip_d     = trip_q;
        finish_d   = finish_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    trip_d   = trip_count;
                    finish_d = 1'b0;
                    state_d  = S_PRE;
                end
            end
            S_PRE: begin
                iter_idx_d = '0;
                state_d    = (trip_q != '0) ? S_ITER_START : S_POST0;
            end
            S_ITER_START: state_d = S_BODY;
            S_BODY: begin
                // abort wins over body_done when both arrive together
                if (abort) begin
                    state_d = S_QUIT;
                end else if (body_done) begin
                    state_d = S_ITER_END;
                end
            end
            S_ITER_END: begin
                if (last_iter) begin
                    state_d = S_POST0;
                end else begin
                    iter_idx_d = iter_idx_q + CNT_WIDTH'(1);
                    state_d    = S_ITER_START;
                end
            end
            S_QUIT: state_d = S_POST0;
            S_POST0: begin
                // finish rises together with the ap_done cycle that follows
                finish_d = 1'b1;
                state_d  = S_POST1;
            end
            S_POST1: begin
                if (ap_start) begin
                    trip_d   = trip_count;
                    finish_d = 1'b0;
                    state_d  = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ap_idle    = (state_q == S_IDLE);
    assign ap_ready   = (state_q == S_POST1);
    assign ap_done    = (state_q == S_POST1);
    assign iter_start = (state_q == S_ITER_START);
    assign iter_end   = (state_q == S_ITER_END);
    assign loop_quit  = (state_q == S_QUIT);
    assign cur_state  = FSM_WIDTH'(state_q);
    assign iter_idx   = iter_idx_q;
    assign finish     = finish_q;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Bench for loop_seq_ctrl: builds each invocation's expected timeline from the
// loop rules (iteration = start, body wait, end) and compares it cycle by cycle.
module tb_loop_seq_ctrl;

    localparam int FW = 4;
    localparam int CW = 4;

    localparam logic [6:0] F_IDLE = 7'b1000000;
    localparam logic [6:0] F_RDY  = 7'b0100000;
    localparam logic [6:0] F_DONE = 7'b0010000;
    localparam logic [6:0] F_IS   = 7'b0001000;
    localparam logic [6:0] F_IE   = 7'b0000100;
    localparam logic [6:0] F_Q    = 7'b0000010;
    localparam logic [6:0] F_FIN  = 7'b0000001;

    logic          clock = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [CW-1:0] trip_count;
    logic          body_done;
    logic          abort;
    logic          ap_idle, ap_ready, ap_done;
    logic [FW-1:0] cur_state;
    logic [CW-1:0] iter_idx;
    logic          iter_start, iter_end, loop_quit, finish;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] idx_m;
    bit            fin_m;

    loop_seq_ctrl #(.FSM_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .ap_start   (ap_start),
        .trip_count (trip_count),
        .body_done  (body_done),
        .abort      (abort),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .cur_state  (cur_state),
        .iter_idx   (iter_idx),
        .iter_start (iter_start),
        .iter_end   (iter_end),
        .loop_quit  (loop_quit),
        .finish     (finish)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [6:0] ef, input logic [CW-1:0] ei, input int es);
        chk_eq($sformatf("%s flags", tag),
               32'({ap_idle, ap_ready, ap_done, iter_start, iter_end, loop_quit, finish}), 32'(ef));
        chk_eq($sformatf("%s iter_idx", tag), 32'(iter_idx), 32'(ei));
        chk_eq($sformatf("%s state", tag), 32'(cur_state), 32'(es));
    endtask

    // Idle for g cycles; the last idle cycle raises ap_start with the given trip.
    task automatic idle_gap(input int g, input logic [CW-1:0] trip);
        for (int k = 1; k <= g; k++) begin
            chk_cycle("idle", F_IDLE | (fin_m ? F_FIN : 7'b0), idx_m, 0);
            ap_start   = (k == g);
            trip_count = (k == g) ? trip : CW'($urandom_range(0, 15));
            body_done  = 1'($urandom_range(0, 1));
            abort      = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // Called in the cycle after the start was accepted (relative cycle 1 = PRE).
    task automatic run_inv(input int n, input int abort_k, input int w_lo, input int w_hi,
                           input bit nxt_start, input logic [CW-1:0] nxt_trip, input string tag);
        logic [6:0]    ef [0:255];
        logic [CW-1:0] ei [0:255];
        int            es [0:255];
        bit            bd [0:255];
        bit            ab [0:255];
        int            c, w, last;
        bit            aborted;
        logic [CW-1:0] fidx;
        aborted = 1'b0;
        for (int k = 0; k < 256; k++) begin
            ef[k] = '0;
            ei[k] = idx_m;
            es[k] = 0;
            bd[k] = 1'($urandom_range(0, 1));
            ab[k] = 1'($urandom_range(0, 1));
        end
        es[1] = 1;
        c = 2;
        for (int i = 0; i < n && !aborted; i++) begin
            es[c] = 2;
            ef[c] = F_IS;
            ei[c] = CW'(i);
            w = $urandom_range(w_lo, w_hi);
            for (int b = 0; b <= w; b++) begin
                es[c+1+b] = 3;
                ei[c+1+b] = CW'(i);
                bd[c+1+b] = 1'b0;
                ab[c+1+b] = 1'b0;
            end
            bd[c+1+w] = 1'b1;
            ei[c+2+w] = CW'(i);
            if (i == abort_k) begin
                ab[c+1+w] = 1'b1;
                es[c+2+w] = 5;
                ef[c+2+w] = F_Q;
                aborted   = 1'b1;
            end else begin
                es[c+2+w] = 4;
                ef[c+2+w] = F_IE;
            end
            c = c + 3 + w;
        end
        fidx = (n == 0) ? '0 : (aborted ? CW'(abort_k) : CW'(n - 1));
        es[c]   = 6;
        ei[c]   = fidx;
        es[c+1] = 7;
        ei[c+1] = fidx;
        ef[c+1] = F_RDY | F_DONE | F_FIN;
        last = c + 1;
        for (int k = 1; k <= last; k++) begin
            chk_cycle($sformatf("%s c%0d", tag, k), ef[k], ei[k], es[k]);
            if (k == last) begin
                ap_start   = nxt_start;
                trip_count = nxt_trip;
            end else begin
                ap_start   = 1'($urandom_range(0, 1));
                trip_count = CW'($urandom_range(0, 15));
            end
            body_done = bd[k];
            abort     = ab[k];
            tick();
        end
        idx_m = fidx;
        fin_m = 1'b1;
    endtask

    initial begin
        int            t, ak;
        bit            pend, nb;
        logic [CW-1:0] ntrip;

        reset      = 1'b0;
        ap_start   = 1'b1;
        body_done  = 1'b1;
        abort      = 1'b1;
        trip_count = 4'd7;
        repeat (3) tick();
        chk_cycle("reset", F_IDLE, '0, 0);
        idx_m = '0;
        fin_m = 1'b0;

        // first start accepted on the first edge out of reset
        reset      = 1'b1;
        ap_start   = 1'b1;
        trip_count = 4'd3;
        body_done  = 1'b0;
        abort      = 1'b0;
        tick();
        run_inv(3, -1, 0, 0, 1'b0, '0, "trip3");
        idle_gap(2, 4'd0);
        run_inv(0, -1, 0, 0, 1'b0, '0, "trip0");
        idle_gap(1, 4'd5);
        run_inv(5, 2, 0, 1, 1'b0, '0, "abort");
        idle_gap(1, 4'd1);
        run_inv(1, -1, 0, 0, 1'b1, 4'd1, "b2b_a");
        run_inv(1, -1, 0, 0, 1'b0, '0, "b2b_b");
        idle_gap(1, 4'd2);
        run_inv(2, -1, 3, 3, 1'b0, '0, "slow");
        idle_gap(1, 4'd15);
        run_inv(15, -1, 0, 1, 1'b0, '0, "full");

        pend  = 1'b0;
        ntrip = '0;
        for (int r = 0; r < 25; r++) begin
            t = pend ? int'(ntrip) : $urandom_range(0, 7);
            if (!pend) idle_gap($urandom_range(1, 3), CW'(t));
            nb    = (r == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            ntrip = CW'($urandom_range(0, 7));
            ak    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (t == 0) ? 0 : t - 1) : -1;
            run_inv(t, ak, 0, 3, nb, ntrip, "rnd");
            pend = nb;
        end

        // reset while in BODY of iteration 1
        idle_gap(1, 4'd3);
        body_done = 1'b1;
        abort     = 1'b0;
        ap_start  = 1'b0;
        repeat (5) tick();
        chk_eq("pre_rst state", 32'(cur_state), 32'd3);
        chk_eq("pre_rst idx", 32'(iter_idx), 32'd1);
        reset = 1'b0;
        tick();
        chk_cycle("mid_rst", F_IDLE, '0, 0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_cycle("post_rst", F_IDLE, '0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
